seq_stage_controller: RTL and testbench
=======================================

Name: seq_stage_controller

Overview:
Multi-cycle sequencer for the Y86-64 SEQ datapath. Owns the architectural PC register and the Y86 status code. Steps each instruction through six one-cycle phases (fetch, decode, execute, memory, writeback, PC update) by issuing one-hot enable strobes to the stage blocks. Supports free-run and single-step operation, stops on halt or fault, and keeps retired-instruction and busy-cycle counters for the bench and debug.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset.
CNT_W, 32, width of the retired and cycles counters.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; while high, instructions execute back-to-back
step  in  1  rising edge executes exactly one instruction
icode  in  4  from fetch; valid during FETCH
instr_valid  in  1  from fetch; 0 means illegal instruction
imem_error  in  1  from fetch; instruction address out of range
dmem_error  in  1  from memory; valid during MEMORY
new_pc  in  64  next-PC from the pc_update block
pc  out  64  architectural PC, drives fetch
fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en  out  1 each  phase strobes, at most one high
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
busy  out  1  high in any phase state
retired  out  CNT_W  count of completed instructions
cycles  out  CNT_W  count of clocks spent busy

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, stat=AOK, all strobes 0, busy 0, retired=0, cycles=0, step edge register cleared. Reset mid-instruction aborts it; there is no partial commit.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP.
- Strobes are Moore outputs of the state register: fetch_en=(state==FETCH), and so on, with pc_en=(state==PCUPD). busy=(state is not IDLE or STOP).
- IDLE -> FETCH when stat==AOK and (run==1 or a rising edge of step). A step edge is detected as step & ~step_q, with step_q registered every cycle. Step edges arriving outside IDLE are dropped and not queued. If run and a step edge coincide, run semantics apply.
- FETCH: evaluate faults at the end of the cycle, in priority order:
  - imem_error -> stat=ADR, go to STOP.
  - else !instr_valid -> stat=INS, go to STOP.
  - else icode==IHALT (0) -> stat=HLT, retired+1, go to STOP. PC is not updated.
  - else -> DECODE.
- DECODE -> EXECUTE -> MEMORY, one cycle each, unconditional.
- MEMORY: if dmem_error, set stat=ADR and go to STOP. wb_en and pc_en never assert for this instruction. Otherwise go to WRITEBACK.
- WRITEBACK -> PCUPD.
- PCUPD: at this edge pc<=new_pc and retired+1. Next state is FETCH if run==1, else IDLE.
- Instruction latency is 6 clocks, FETCH through PCUPD. Sustained throughput under run is 1 instruction per 6 clocks, with no IDLE bubble between instructions.
- STOP is absorbing: stays there until reset and ignores run and step. stat holds its fault code.
- cycles increments on every clock edge where busy==1. Both counters wrap modulo 2^CNT_W silently.
- pc changes only at a PCUPD edge or on reset. new_pc is ignored in all other states.
- Lowering run mid-instruction does not abort: the current instruction completes, then the FSM goes to IDLE.

Decomposition:
- Shared package y86_ctrl_pkg: stat codes (STAT_AOK=1, STAT_HLT=2, STAT_ADR=3, STAT_INS=4), icode constants (IHALT through IPOPQ), and the phase state enumeration. Stage blocks reuse these.
- One natural sub-module, seq_perf_counters: holds the retired and cycles counters, with inputs busy and retire_pulse and parameter CNT_W.

Test Plan:
1. Reset with RESET_PC=34, run=0 -> pc=34, stat=1, busy=0, all strobes 0, retired=0, cycles=0.
2. Single step (one-cycle step pulse, icode=2 valid, new_pc=36) -> fetch_en through pc_en each high for exactly 1 cycle in order; pc=36 after 6 clocks; retired=1; cycles=6; FSM returns to IDLE. A second step pulse issued while busy has no effect.
3. run=1 for three non-halt instructions, then icode=0 on the fourth fetch -> retired=4, stat=2, FSM in STOP; later step or run pulses cause no strobes.
4. imem_error=1 and instr_valid=0 together during FETCH -> stat=3 (ADR wins over INS), pc unchanged, retired unchanged. Separately, instr_valid=0 alone -> stat=4.
5. dmem_error=1 during MEMORY -> stat=3, wb_en and pc_en never assert, pc unchanged, cycles=4.
6. rst_n low during EXECUTE, asynchronously with no clock edge -> outputs return to reset values immediately; after release with run=1, FETCH begins on the next clock.

Source files
------------

// File: rtl/y86_ctrl_pkg.sv
// Shared control definitions for the Y86-64 SEQ datapath: status codes,
// instruction codes and the sequencer phase enumeration.
package y86_ctrl_pkg;

    // Architectural status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Sequencer phases; IDLE and STOP are the only non-busy states
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_FETCH,
        PH_DECODE,
        PH_EXECUTE,
        PH_MEMORY,
        PH_WRITEBACK,
        PH_PCUPD,
        PH_STOP
    } phase_e;

endpackage

// File: rtl/seq_perf_counters.sv
// Retired-instruction and busy-cycle counters for bench and debug visibility.
// Both counters wrap silently.
module seq_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             busy,
    input  logic             retire_pulse,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    // Next counter values: bump on each retire pulse and each busy clock
    always_comb begin
        retired_d = retired_q;
        cycles_d  = cycles_q;
        if (retire_pulse) retired_d = retired_q + CNT_W'(1);
        if (busy)         cycles_d  = cycles_q + CNT_W'(1);
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            retired_q <= retired_d;
            cycles_q  <= cycles_d;
        end
    end

    assign retired = retired_q;
    assign cycles  = cycles_q;

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath. Walks each instruction
// through six one-cycle phases, owns the PC and status code, and halts for
// good on HLT or any fault until reset.
module seq_stage_controller
    import y86_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    input  logic [63:0]      new_pc,
    output logic [63:0]      pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    phase_e      state_q, state_d;
    logic [2:0]  stat_q, stat_d;
    logic [63:0] pc_q, pc_d;
    logic        step_q;
    logic        step_edge;
    logic        retire_pulse;

    // A step only counts on its rising edge; edges seen outside IDLE are lost
    assign step_edge = step & ~step_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PH_IDLE;
        else        state_q <= state_d;
    end

    // Architectural PC, status code and step history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            stat_q <= STAT_AOK;
            step_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            stat_q <= stat_d;
            step_q <= step;
        end
    end

    // Next-state logic with fault checks at FETCH and MEMORY
    always_comb begin
        state_d      = state_q;
        stat_d       = stat_q;
        pc_d         = pc_q;
        retire_pulse = 1'b0;
        case (state_q)
            PH_IDLE: begin
                if (stat_q == STAT_AOK && (run || step_edge)) state_d = PH_FETCH;
            end
            PH_FETCH: begin
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = PH_STOP;
                end else if (!instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = PH_STOP;
                end else if (icode == IHALT) begin
                    stat_d       = STAT_HLT;
                    retire_pulse = 1'b1;
                    state_d      = PH_STOP;
                end else begin
                    state_d = PH_DECODE;
                end
            end
            PH_DECODE:  state_d = PH_EXECUTE;
            PH_EXECUTE: state_d = PH_MEMORY;
            PH_MEMORY: begin
                if (dmem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = PH_STOP;
                end else begin
                    state_d = PH_WRITEBACK;
                end
            end
            PH_WRITEBACK: state_d = PH_PCUPD;
            PH_PCUPD: begin
                pc_d         = new_pc;
                retire_pulse = 1'b1;
                state_d      = run ? PH_FETCH : PH_IDLE;
            end
            PH_STOP: state_d = PH_STOP;
            default: state_d = PH_IDLE;
        endcase
    end

    // Moore phase strobes and busy flag decoded from the state register
    always_comb begin
        fetch_en   = 1'b0;
        decode_en  = 1'b0;
        execute_en = 1'b0;
        mem_en     = 1'b0;
        wb_en      = 1'b0;
        pc_en      = 1'b0;
        busy       = 1'b1;
        case (state_q)
            PH_FETCH:     fetch_en   = 1'b1;
            PH_DECODE:    decode_en  = 1'b1;
            PH_EXECUTE:   execute_en = 1'b1;
            PH_MEMORY:    mem_en     = 1'b1;
            PH_WRITEBACK: wb_en      = 1'b1;
            PH_PCUPD:     pc_en      = 1'b1;
            default:      busy       = 1'b0;
        endcase
    end

    seq_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .busy         (busy),
        .retire_pulse (retire_pulse),
        .retired      (retired),
        .cycles       (cycles)
    );

    assign pc   = pc_q;
    assign stat = stat_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed bench for seq_stage_controller with a per-cycle reference model.
module tb_seq_stage_controller;

    localparam logic [63:0] RPC = 64'd34;
    localparam int          CW  = 32;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          step;
    logic [3:0]    icode;
    logic          instr_valid;
    logic          imem_error;
    logic          dmem_error;
    logic [63:0]   new_pc;
    logic [63:0]   pc;
    logic          fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en;
    logic [2:0]    stat;
    logic          busy;
    logic [CW-1:0] retired;
    logic [CW-1:0] cycles;

    int   tests = 0;
    int   fails = 0;
    logic checkEn = 1'b0;

    seq_stage_controller #(
        .RESET_PC(RPC),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .icode      (icode),
        .instr_valid(instr_valid),
        .imem_error (imem_error),
        .dmem_error (dmem_error),
        .new_pc     (new_pc),
        .pc         (pc),
        .fetch_en   (fetch_en),
        .decode_en  (decode_en),
        .execute_en (execute_en),
        .mem_en     (mem_en),
        .wb_en      (wb_en),
        .pc_en      (pc_en),
        .stat       (stat),
        .busy       (busy),
        .retired    (retired),
        .cycles     (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes packed in phase order, fetch in the MSB
    function automatic logic [5:0] strobes();
        return {fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [3:0] ic,
                                 input logic v, input logic ie, input logic de,
                                 input logic [63:0] np);
        run         = r;
        step        = s;
        icode       = ic;
        instr_valid = v;
        imem_error  = ie;
        dmem_error  = de;
        new_pc      = np;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reference model: mPos is the position inside the six-clock instruction
    // window (1..6), 0 means waiting to start, 7 means stopped for good.
    logic [63:0] mPc;
    logic [2:0]  mStat;
    int          mPos;
    logic [31:0] mRet;
    logic [31:0] mCyc;
    logic        mStepQ;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPc    <= RPC;
            mStat  <= 3'd1;
            mPos   <= 0;
            mRet   <= 0;
            mCyc   <= 0;
            mStepQ <= 1'b0;
        end else begin
            mStepQ <= step;
            if (mPos >= 1 && mPos <= 6) mCyc <= mCyc + 1;
            if (mPos == 0) begin
                if (mStat == 3'd1 && (run || (step && !mStepQ))) mPos <= 1;
            end else if (mPos == 1) begin
                if (imem_error) begin
                    mStat <= 3'd3; mPos <= 7;
                end else if (!instr_valid) begin
                    mStat <= 3'd4; mPos <= 7;
                end else if (icode == 4'd0) begin
                    mStat <= 3'd2; mRet <= mRet + 1; mPos <= 7;
                end else begin
                    mPos <= 2;
                end
            end else if (mPos == 4 && dmem_error) begin
                mStat <= 3'd3; mPos <= 7;
            end else if (mPos == 6) begin
                mPc  <= new_pc;
                mRet <= mRet + 1;
                mPos <= run ? 1 : 0;
            end else if (mPos != 7) begin
                mPos <= mPos + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model pc", pc, mPc);
            checkOutput("model stat", {61'd0, stat}, {61'd0, mStat});
            checkOutput("model busy", {63'd0, busy}, {63'd0, (mPos >= 1 && mPos <= 6)});
            checkOutput("model strobes", {58'd0, strobes()},
                        (mPos >= 1 && mPos <= 6) ? (64'd32 >> (mPos - 1)) : 64'd0);
            checkOutput("model retired", {32'd0, retired}, {32'd0, mRet});
            checkOutput("model cycles", {32'd0, cycles}, {32'd0, mCyc});
        end
    end

    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 64'd36);
        #2 rst_n = 1'b0;
        #1;
        // 1: reset values
        checkOutput("reset pc", pc, 64'd34);
        checkOutput("reset stat", {61'd0, stat}, 64'd1);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset strobes", {58'd0, strobes()}, 64'd0);
        checkOutput("reset retired", {32'd0, retired}, 64'd0);
        checkOutput("reset cycles", {32'd0, cycles}, 64'd0);
        tick();
        checkEn = 1'b1;
        tick();
        rst_n = 1'b1;

        // 2: single step, with a second pulse while busy that must be dropped
        step = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("step strobe order", {58'd0, strobes()}, 64'd32 >> k);
            if (k == 0) step = 1'b0;
            if (k == 2) step = 1'b1;
            if (k == 3) step = 1'b0;
        end
        tick();
        checkOutput("step pc", pc, 64'd36);
        checkOutput("step retired", {32'd0, retired}, 64'd1);
        checkOutput("step cycles", {32'd0, cycles}, 64'd6);
        checkOutput("step idle", {63'd0, busy}, 64'd0);
        tick();
        tick();
        checkOutput("dropped step", {58'd0, strobes()}, 64'd0);

        // 3: free run, three instructions then HALT
        applyReset();
        applyStimulus(1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 64'd100);
        for (int i = 0; i < 3; i++) begin
            new_pc = 64'd100 + 64'(i * 10);
            repeat (6) tick();
        end
        icode = 4'd0;
        tick();
        checkOutput("halt fetch", {63'd0, fetch_en}, 64'd1);
        tick();
        checkOutput("halt stat", {61'd0, stat}, 64'd2);
        checkOutput("halt retired", {32'd0, retired}, 64'd4);
        checkOutput("halt cycles", {32'd0, cycles}, 64'd19);
        checkOutput("halt pc", pc, 64'd120);
        run = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        run = 1'b1;
        repeat (3) tick();
        checkOutput("stop absorbing", {58'd0, strobes()}, 64'd0);
        checkOutput("stop stat held", {61'd0, stat}, 64'd2);

        // 4: ADR beats INS at fetch, then INS alone
        applyReset();
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 64'd50);
        tick();
        step = 1'b0;
        tick();
        checkOutput("imem stat", {61'd0, stat}, 64'd3);
        checkOutput("imem pc", pc, 64'd34);
        checkOutput("imem retired", {32'd0, retired}, 64'd0);
        applyReset();
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 64'd50);
        tick();
        step = 1'b0;
        tick();
        checkOutput("ins stat", {61'd0, stat}, 64'd4);

        // 5: data memory fault
        applyReset();
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 64'd200);
        tick();
        step = 1'b0;
        repeat (4) tick();
        checkOutput("dmem stat", {61'd0, stat}, 64'd3);
        checkOutput("dmem cycles", {32'd0, cycles}, 64'd4);
        checkOutput("dmem pc", pc, 64'd34);
        checkOutput("dmem retired", {32'd0, retired}, 64'd0);
        repeat (3) tick();
        checkOutput("dmem no wb/pc", {62'd0, wb_en, pc_en}, 64'd0);
        dmem_error = 1'b0;

        // 6: asynchronous reset during EXECUTE
        applyReset();
        applyStimulus(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 64'd300);
        repeat (3) tick();
        checkOutput("pre-abort execute", {63'd0, execute_en}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort pc", pc, 64'd34);
        checkOutput("abort stat", {61'd0, stat}, 64'd1);
        checkOutput("abort busy", {63'd0, busy}, 64'd0);
        checkOutput("abort strobes", {58'd0, strobes()}, 64'd0);
        checkOutput("abort cycles", {32'd0, cycles}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("restart fetch", {63'd0, fetch_en}, 64'd1);
        tick();
        checkOutput("restart cycles", {32'd0, cycles}, 64'd1);
        tick();

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
